fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 209 ++++++++++++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end. Issues word-aligned requests to instruction
// memory, buffers up to two returned words (with their addresses) in a small
// FIFO, and presents the oldest one to decode. Handles control-flow redirects
// and a permanent halt, including the case where a memory request is already
// outstanding and must be completed before the fetch stream can change.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst          : asynchronous active-high reset
//   imem_req     : request to instruction memory
//   imem_addr    : word-aligned request address
//   imem_ready   : memory completes the request this cycle, imem_rdata valid
//   imem_rdata   : returned instruction word
//   inst_valid   : FIFO head is available to decode
//   inst         : FIFO head instruction
//   inst_pc      : FIFO head address
//   inst_ready   : decode accepts the head this cycle
//   redirect     : taken branch/jump, flush and refetch from redirect_pc
//   redirect_pc  : new fetch address (low two bits ignored)
//   halt         : stop fetching until reset
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_KILL  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] kill_addr_q, kill_addr_d;
    logic        halt_lat_q, halt_lat_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] fifo_pc_q   [2];
    logic [31:0] fifo_pc_d   [2];
    logic [31:0] fifo_inst_q [2];
    logic [31:0] fifo_inst_d [2];

    logic        req_s;
    logic [31:0] addr_s;
    logic        hs_s;
    logic        pending_s;
    logic        pop_s;
    logic [1:0]  cnt_pop_s;
    logic [31:0] redirect_aligned_s;

    // Request generation from the current state; reset masks it immediately
    // so an in-flight request is abandoned without waiting for a handshake.
    always_comb begin
        req_s  = 1'b0;
        addr_s = fetch_pc_q;
        case (state_q)
            ST_FETCH: begin
                req_s  = (count_q < 2'd2);
                addr_s = fetch_pc_q;
            end
            ST_KILL: begin
                req_s  = 1'b1;
                addr_s = kill_addr_q;
            end
            ST_HALT: begin
                req_s  = 1'b0;
                addr_s = fetch_pc_q;
            end
            default: begin
                req_s  = 1'b0;
                addr_s = fetch_pc_q;
            end
        endcase
    end

    assign imem_req           = req_s & ~rst;
    assign imem_addr          = addr_s;
    assign inst_valid         = (count_q != 2'd0) && (state_q != ST_HALT);
    assign inst               = fifo_inst_q[0];
    assign inst_pc            = fifo_pc_q[0];
    assign hs_s               = req_s & imem_ready;
    assign pending_s          = req_s & ~imem_ready;
    assign pop_s              = inst_valid & inst_ready;
    assign redirect_aligned_s = redirect_pc & 32'hFFFF_FFFC;

    // Next-state, fetch PC and FIFO update.
    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        kill_addr_d    = kill_addr_q;
        halt_lat_d     = halt_lat_q;
        count_d        = count_q;
        fifo_pc_d[0]   = fifo_pc_q[0];
        fifo_pc_d[1]   = fifo_pc_q[1];
        fifo_inst_d[0] = fifo_inst_q[0];
        fifo_inst_d[1] = fifo_inst_q[1];
        cnt_pop_s      = count_q;
        case (state_q)
            ST_FETCH: begin
                if (halt) begin
                    // Halt wins over a same-cycle redirect.
                    count_d = 2'd0;
                    if (pending_s) begin
                        halt_lat_d  = 1'b1;
                        kill_addr_d = fetch_pc_q;
                        state_d     = ST_KILL;
                    end else begin
                        state_d = ST_HALT;
                    end
                end else if (redirect) begin
                    // Flush beats a same-cycle pop; any response this cycle is dropped.
                    count_d    = 2'd0;
                    fetch_pc_d = redirect_aligned_s;
                    if (pending_s) begin
                        kill_addr_d = fetch_pc_q;
                        state_d     = ST_KILL;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    if (pop_s) begin
                        cnt_pop_s      = count_q - 2'd1;
                        fifo_pc_d[0]   = fifo_pc_q[1];
                        fifo_inst_d[0] = fifo_inst_q[1];
                    end else begin
                        cnt_pop_s = count_q;
                    end
                    // A push only happens when count < 2, so after the pop
                    // the write slot index is 0 or 1.
                    if (hs_s) begin
                        fifo_pc_d[cnt_pop_s[0]]   = fetch_pc_q;
                        fifo_inst_d[cnt_pop_s[0]] = imem_rdata;
                        fetch_pc_d                = fetch_pc_q + 32'd4;
                        count_d                   = cnt_pop_s + 2'd1;
                    end else begin
                        count_d = cnt_pop_s;
                    end
                end
            end
            ST_KILL: begin
                count_d = 2'd0;
                if (halt) begin
                    halt_lat_d = 1'b1;
                end else begin
                    halt_lat_d = halt_lat_q;
                end
                if (redirect) begin
                    fetch_pc_d = redirect_aligned_s;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                if (imem_ready) begin
                    state_d = (halt_lat_q || halt) ? ST_HALT : ST_FETCH;
                end else begin
                    state_d = ST_KILL;
                end
            end
            ST_HALT: begin
                count_d = 2'd0;
                state_d = ST_HALT;
            end
            default: begin
                count_d = 2'd0;
                state_d = ST_FETCH;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_FETCH;
            fetch_pc_q     <= RESET_PC;
            kill_addr_q    <= 32'h0000_0000;
            halt_lat_q     <= 1'b0;
            count_q        <= 2'd0;
            fifo_pc_q[0]   <= 32'h0000_0000;
            fifo_pc_q[1]   <= 32'h0000_0000;
            fifo_inst_q[0] <= 32'h0000_0000;
            fifo_inst_q[1] <= 32'h0000_0000;
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            kill_addr_q    <= kill_addr_d;
            halt_lat_q     <= halt_lat_d;
            count_q        <= count_d;
            fifo_pc_q[0]   <= fifo_pc_d[0];
            fifo_pc_q[1]   <= fifo_pc_d[1];
            fifo_inst_q[0] <= fifo_inst_d[0];
            fifo_inst_q[1] <= fifo_inst_d[1];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Inputs change on the falling edge; outputs
// are compared on the falling edge before new inputs are applied. A second
// instance with a wrapping reset PC shares clock and reset.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_rdata;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;

    int n_checks;
    int n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1300_0013 ^ a;
    endfunction

    assign imem_rdata   = mem_word(imem_addr);
    assign w_imem_rdata = mem_word(w_imem_addr);

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (w_imem_req),
        .imem_addr   (w_imem_addr),
        .imem_ready  (1'b1),
        .imem_rdata  (w_imem_rdata),
        .inst_valid  (w_inst_valid),
        .inst        (w_inst),
        .inst_pc     (w_inst_pc),
        .inst_ready  (1'b1),
        .redirect    (1'b0),
        .redirect_pc (32'h0000_0000),
        .halt        (1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_neg();
        @(negedge clk);
    endtask

    // Hold reset for two cycles and release it on a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        next_neg();
        next_neg();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        imem_ready  = 1'b1;
        inst_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;
        halt        = 1'b0;

        // Reset state.
        next_neg();
        check_eq("rst_req",   {31'd0, imem_req},   32'd0);
        check_eq("rst_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rst_inst",  inst,                32'd0);
        check_eq("rst_pc",    inst_pc,             32'd0);
        next_neg();
        rst = 1'b0;
        #1;
        check_eq("first_req",  {31'd0, imem_req}, 32'd1);
        check_eq("first_addr", imem_addr,         32'h0000_0000);
        check_eq("wrap_addr0", w_imem_addr,       32'hFFFF_FFF8);

        // Streaming with memory and decode always ready.
        next_neg();
        check_eq("s_addr1",  imem_addr,          32'h0000_0004);
        check_eq("s_valid1", {31'd0, inst_valid}, 32'd1);
        check_eq("s_pc1",    inst_pc,            32'h0000_0000);
        check_eq("s_inst1",  inst,               mem_word(32'h0000_0000));
        check_eq("wrap_addr1", w_imem_addr,      32'hFFFF_FFFC);
        next_neg();
        check_eq("s_addr2",  imem_addr,          32'h0000_0008);
        check_eq("s_pc2",    inst_pc,            32'h0000_0004);
        check_eq("wrap_addr2", w_imem_addr,      32'h0000_0000);
        check_eq("wrap_pc2", w_inst_pc,          32'hFFFF_FFFC);

        // Decode backpressure: two words buffered, request drops.
        do_reset();
        inst_ready = 1'b0;
        repeat (4) next_neg();
        check_eq("bp_req",   {31'd0, imem_req},   32'd0);
        check_eq("bp_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("bp_pc0",   inst_pc,             32'h0000_0000);
        inst_ready = 1'b1;
        next_neg();
        check_eq("bp_pc1",   inst_pc,             32'h0000_0004);
        check_eq("bp_inst1", inst,                mem_word(32'h0000_0004));
        check_eq("bp_req1",  {31'd0, imem_req},   32'd1);
        check_eq("bp_addr1", imem_addr,           32'h0000_0008);
        next_neg();
        check_eq("bp_pc2",   inst_pc,             32'h0000_0008);
        check_eq("bp_addr2", imem_addr,           32'h0000_000C);

        // Redirect with memory ready: flush, refetch aligned target.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        next_neg();
        redirect = 1'b0;
        check_eq("rd_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rd_req",   {31'd0, imem_req},   32'd1);
        check_eq("rd_addr",  imem_addr,           32'h0000_0100);
        next_neg();
        check_eq("rd_valid2", {31'd0, inst_valid}, 32'd1);
        check_eq("rd_pc",     inst_pc,             32'h0000_0100);
        check_eq("rd_inst",   inst,                mem_word(32'h0000_0100));

        // Redirect during a stalled request at 0x8.
        do_reset();
        next_neg();
        next_neg();
        check_eq("k_addr0", imem_addr, 32'h0000_0008);
        imem_ready = 1'b0;
        next_neg();
        check_eq("k_addr1",  imem_addr,           32'h0000_0008);
        check_eq("k_valid1", {31'd0, inst_valid}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        next_neg();
        redirect = 1'b0;
        check_eq("k_addr2",  imem_addr,           32'h0000_0008);
        check_eq("k_req2",   {31'd0, imem_req},   32'd1);
        check_eq("k_valid2", {31'd0, inst_valid}, 32'd0);
        next_neg();
        check_eq("k_addr3",  imem_addr,           32'h0000_0008);
        check_eq("k_valid3", {31'd0, inst_valid}, 32'd0);
        imem_ready = 1'b1;
        next_neg();
        check_eq("k_addr4",  imem_addr,           32'h0000_0040);
        check_eq("k_valid4", {31'd0, inst_valid}, 32'd0);
        next_neg();
        check_eq("k_valid5", {31'd0, inst_valid}, 32'd1);
        check_eq("k_pc5",    inst_pc,             32'h0000_0040);

        // Reset while a request is outstanding drops it at once.
        imem_ready = 1'b0;
        next_neg();
        check_eq("mr_req_pre", {31'd0, imem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mr_req", {31'd0, imem_req}, 32'd0);

        // Halt (with a same-cycle redirect) during a stalled request.
        do_reset();
        check_eq("h_addr0", imem_addr, 32'h0000_0000);
        halt        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0080;
        next_neg();
        halt     = 1'b0;
        redirect = 1'b0;
        check_eq("h_req1",   {31'd0, imem_req},   32'd1);
        check_eq("h_addr1",  imem_addr,           32'h0000_0000);
        check_eq("h_valid1", {31'd0, inst_valid}, 32'd0);
        imem_ready = 1'b1;
        next_neg();
        check_eq("h_req2",   {31'd0, imem_req},   32'd0);
        check_eq("h_valid2", {31'd0, inst_valid}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        next_neg();
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("h_req_hold",   {31'd0, imem_req},   32'd0);
            check_eq("h_valid_hold", {31'd0, inst_valid}, 32'd0);
            next_neg();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
